rgb_to_ypbpr: RTL and testbench
===============================

Name:
rgb_to_ypbpr

Overview:
- Pipelined colour-space converter on the final video path of the MiST-family frame, after the OSD mixer and before the VGA/SCART pins.
- When `ena`=1, converts WIDTH-bit RGB into component YPbPr, carried on the same pins: Pr→red, Y→green, Pb→blue.
- When `ena`=0, passes RGB through unchanged.
- Sync signals are delayed to match the pixel latency in both modes.

Parameters:
- WIDTH, 6, bits per colour component on input and output; legal range 4..8.

Ports:
- clk input 1: pixel/system clock; all registers update on its rising edge.
- rst input 1: asynchronous, active-high reset.
- ena input 1: 1 = YPbPr conversion, 0 = RGB pass-through; sampled every cycle.
- red_in input WIDTH: red component.
- green_in input WIDTH: green component.
- blue_in input WIDTH: blue component.
- hs_in input 1: horizontal sync.
- vs_in input 1: vertical sync.
- cs_in input 1: composite sync.
- red_out output WIDTH: Pr when ena=1, else red.
- green_out output WIDTH: Y when ena=1, else green.
- blue_out output WIDTH: Pb when ena=1, else blue.
- hs_out output 1: hs_in delayed 2 cycles.
- vs_out output 1: vs_in delayed 2 cycles.
- cs_out output 1: cs_in delayed 2 cycles.

Behaviour:
- Reset: all pipeline registers and all outputs go to 0 immediately (asynchronous); first valid output appears 2 clocks after rst deasserts.
- Latency: exactly 2 clocks from inputs to every output, in both modes. ena is pipelined alongside the data, so switching ena mid-frame never misaligns pixels and sync.
- Stage 0, extension: each component is widened to 8 bits by MSB replication. c8 = {c, c[WIDTH-1 -: 8-WIDTH]}; for WIDTH=8, c8 = c. Example, WIDTH=6: 63→255, 32→130, 0→0.
- Stage 1 (register): signed products, at least 18-bit two's complement.
  - Y terms: 77·R8, 150·G8, 29·B8.
  - Pb terms: 128·B8, −43·R8, −85·G8.
  - Pr terms: 128·R8, −107·G8, −21·B8.
  - Also registered in stage 1: ena, the raw input colours, and the syncs.
- Stage 2 (register):
  - Ys = 77R+150G+29B+128; Y8 = Ys>>8 (range 0..255, no clamp needed).
  - Pbs = 128B−43R−85G+32896; Pb8 = Pbs>>8, clamped to 0..255.
  - Prs = 128R−107G−21B+32896; Pr8 = Prs>>8, clamped to 0..255.
  - Output component = top WIDTH bits of the 8-bit result (truncate, no further rounding).
- Pass-through (delayed ena=0): outputs are the original WIDTH-bit inputs, unmodified, after 2 cycles.
- Syncs: pure 2-stage delay with no inversion, independent of ena.
- No handshake; one pixel accepted and one produced every clock.

Test Plan:
- WIDTH=6, ena=1, R=G=B=63 → after 2 clks, green_out=63, red_out=32, blue_out=32.
- ena=1, R=G=B=0 → green_out=0, red_out=32, blue_out=32.
- ena=1, R=63, G=0, B=0:
  - green_out = (77·255+128)>>8 = 77 → 19.
  - blue_out = (−10965+32896)>>8 = 85 → 21.
  - red_out: 65536>>8 = 256, clamped to 255 → 63.
- ena=1, B=63 only → blue_out=63 (clamp), green_out=7 (29·255+128 >> 8 = 29 → 7).
- ena=0, R=5, G=40, B=17, toggling hs/vs/cs → outputs R=5, G=40, B=17 and syncs equal inputs exactly 2 clks later; toggle ena mid-stream and confirm no pixel/sync skew.
- Assert rst mid-stream → all outputs 0 immediately; after release, outputs valid from the 2nd clock onward.

Source files
------------

// File: rtl/rgb_to_ypbpr.sv
// rgb_to_ypbpr: two-stage pipelined RGB to YPbPr converter with RGB bypass.
// Pr, Y and Pb are carried on the red, green and blue pins; syncs track the pixel latency.
module rgb_to_ypbpr #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] red_in,
    input  logic [WIDTH-1:0] green_in,
    input  logic [WIDTH-1:0] blue_in,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic             cs_in,
    output logic [WIDTH-1:0] red_out,
    output logic [WIDTH-1:0] green_out,
    output logic [WIDTH-1:0] blue_out,
    output logic             hs_out,
    output logic             vs_out,
    output logic             cs_out
);
    // Top 8 bits of {c, c} give MSB replication for every legal WIDTH.
    function automatic logic [7:0] ext(input logic [WIDTH-1:0] c);
        return 8'({c, c} >> (2 * WIDTH - 8));
    endfunction

    logic [7:0] r8, g8, b8;
    logic signed [17:0] y_r, y_g, y_b, pb_r, pb_g, pb_b, pr_r, pr_g, pr_b;
    logic signed [17:0] ys, pbs, prs;
    logic [7:0] y8, pb8, pr8;
    logic [WIDTH-1:0] r1, g1, b1;
    logic ena1, hs1, vs1, cs1;
    logic unused;

    assign r8 = ext(red_in);
    assign g8 = ext(green_in);
    assign b8 = ext(blue_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_r  <= '0;
            y_g  <= '0;
            y_b  <= '0;
            pb_r <= '0;
            pb_g <= '0;
            pb_b <= '0;
            pr_r <= '0;
            pr_g <= '0;
            pr_b <= '0;
            r1   <= '0;
            g1   <= '0;
            b1   <= '0;
            ena1 <= 1'b0;
            hs1  <= 1'b0;
            vs1  <= 1'b0;
            cs1  <= 1'b0;
        end else begin
            y_r  <= 18'sd77 * $signed({10'd0, r8});
            y_g  <= 18'sd150 * $signed({10'd0, g8});
            y_b  <= 18'sd29 * $signed({10'd0, b8});
            pb_r <= -18'sd43 * $signed({10'd0, r8});
            pb_g <= -18'sd85 * $signed({10'd0, g8});
            pb_b <= 18'sd128 * $signed({10'd0, b8});
            pr_r <= 18'sd128 * $signed({10'd0, r8});
            pr_g <= -18'sd107 * $signed({10'd0, g8});
            pr_b <= -18'sd21 * $signed({10'd0, b8});
            r1   <= red_in;
            g1   <= green_in;
            b1   <= blue_in;
            ena1 <= ena;
            hs1  <= hs_in;
            vs1  <= vs_in;
            cs1  <= cs_in;
        end
    end

    // Y never leaves 0..255; chroma sums stay below 2^17, so bit 16 marks overflow.
    always_comb begin
        ys  = y_r + y_g + y_b + 18'sd128;
        pbs = pb_b + pb_r + pb_g + 18'sd32896;
        prs = pr_r + pr_g + pr_b + 18'sd32896;
        y8  = ys[15:8];
        pb8 = pbs[17] ? 8'd0 : pbs[16] ? 8'hff : pbs[15:8];
        pr8 = prs[17] ? 8'd0 : prs[16] ? 8'hff : prs[15:8];
    end

    assign unused = ^{ys, pbs, prs, y8, pb8, pr8};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red_out   <= '0;
            green_out <= '0;
            blue_out  <= '0;
            hs_out    <= 1'b0;
            vs_out    <= 1'b0;
            cs_out    <= 1'b0;
        end else begin
            red_out   <= ena1 ? pr8[7 -: WIDTH] : r1;
            green_out <= ena1 ? y8[7 -: WIDTH] : g1;
            blue_out  <= ena1 ? pb8[7 -: WIDTH] : b1;
            hs_out    <= hs1;
            vs_out    <= vs1;
            cs_out    <= cs1;
        end
    end
endmodule

// File: tb/tb_rgb_to_ypbpr.sv
// tb_rgb_to_ypbpr: directed vector bench for rgb_to_ypbpr at WIDTH=6.
module tb_rgb_to_ypbpr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;
    logic [5:0] red_in = '0, green_in = '0, blue_in = '0;
    logic hs_in = 1'b0, vs_in = 1'b0, cs_in = 1'b0;
    logic [5:0] red_out, green_out, blue_out;
    logic hs_out, vs_out, cs_out;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       en;
        logic [5:0] r, g, b;
        logic [2:0] sy;
        logic [5:0] er, eg, eb;
    } vec_t;

    vec_t v[8];

    rgb_to_ypbpr #(.WIDTH(6)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .hs_in(hs_in), .vs_in(vs_in), .cs_in(cs_in),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .hs_out(hs_out), .vs_out(vs_out), .cs_out(cs_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [20:0] exp);
        logic [20:0] got;
        got = {red_out, green_out, blue_out, hs_out, vs_out, cs_out};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got r=%0d g=%0d b=%0d sync=%b expected r=%0d g=%0d b=%0d sync=%b",
                     nm, got[20:15], got[14:9], got[8:3], got[2:0],
                     exp[20:15], exp[14:9], exp[8:3], exp[2:0]);
        end
    endtask

    task automatic drive(input vec_t x);
        ena = x.en;
        red_in = x.r;
        green_in = x.g;
        blue_in = x.b;
        {hs_in, vs_in, cs_in} = x.sy;
    endtask

    function automatic logic [20:0] expv(input vec_t x);
        return {x.er, x.eg, x.eb, x.sy};
    endfunction

    initial begin
        v[0] = '{1'b1, 6'd63, 6'd63, 6'd63, 3'b111, 6'd32, 6'd63, 6'd32};
        v[1] = '{1'b1, 6'd0,  6'd0,  6'd0,  3'b000, 6'd32, 6'd0,  6'd32};
        v[2] = '{1'b1, 6'd63, 6'd0,  6'd0,  3'b100, 6'd63, 6'd19, 6'd21};
        v[3] = '{1'b1, 6'd0,  6'd0,  6'd63, 3'b010, 6'd26, 6'd7,  6'd63};
        v[4] = '{1'b0, 6'd5,  6'd40, 6'd17, 3'b001, 6'd5,  6'd40, 6'd17};
        v[5] = '{1'b1, 6'd0,  6'd63, 6'd0,  3'b101, 6'd5,  6'd37, 6'd10};
        v[6] = '{1'b0, 6'd63, 6'd0,  6'd32, 3'b011, 6'd63, 6'd0,  6'd32};
        v[7] = '{1'b1, 6'd32, 6'd0,  6'd0,  3'b110, 6'd48, 6'd9,  6'd26};

        #1 check("reset_state", 21'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Isolated vectors: hold each pixel, read it back after two clocks.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(v[i]);
            @(negedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), expv(v[i]));
        end

        // Back-to-back stream with ena toggling: output i must match vector i-2.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) check($sformatf("stream%0d", i - 2), expv(v[i - 2]));
            if (i < 8) drive(v[i]);
        end

        // Asynchronous reset mid-stream, then recovery latency.
        drive(v[0]);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset", expv(v[0]));
        #2 rst = 1'b1;
        #1 check("reset_async", 21'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_clk1", 21'd0);
        @(negedge clk);
        check("reset_clk2", expv(v[0]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
